// File: rtl/noc_outport_alloc.sv
// Per-output wormhole allocator: packet-granular round-robin grant, held until the tail flit, gated by downstream credits.
// Zero latency (grant/xfer/sel are combinational); no flit is granted while credit_cnt is 0.
module noc_outport_alloc #(
  parameter  int NPORT   = 5,
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1),
  localparam int SW      = $clog2(NPORT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req_i,
  input  logic [NPORT-1:0] tail_i,
  input  logic             credit_ret_i,
  output logic [NPORT-1:0] grant_o,
  output logic             xfer_o,
  output logic [SW-1:0]    sel_o,
  output logic             busy_o,
  output logic [CW-1:0]    credit_cnt_o,
  output logic             err_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [SW-1:0]   owner;
  logic [SW-1:0]   rr_ptr;
  logic [CW-1:0]   credit_cnt;
  logic            err;

  logic            found;
  logic [SW-1:0]   win;
  logic [SW:0]     idx;
  logic [NPORT-1:0] grant;
  logic            have_credit;
  logic [SW-1:0]   win_next;

  assign have_credit = (credit_cnt != '0);

  // Rotating priority search from rr_ptr; LOCKED only considers the owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    grant = '0;
    if (!rst && have_credit) begin
      if (state == IDLE) begin
        for (int i = 0; i < NPORT; i++) begin
          idx = {1'b0, rr_ptr} + (SW + 1)'(i);
          if (idx >= (SW + 1)'(NPORT))
            idx = idx - (SW + 1)'(NPORT);
          if (!found && req_i[idx[SW-1:0]]) begin
            found = 1'b1;
            win   = idx[SW-1:0];
          end
        end
      end else if (req_i[owner]) begin
        found = 1'b1;
        win   = owner;
      end
    end
    if (found)
      grant[win] = 1'b1;
  end

  assign win_next = (win == SW'(NPORT - 1)) ? '0 : win + 1'b1;

  assign grant_o      = grant;
  assign xfer_o       = found;
  assign sel_o        = win;
  assign busy_o       = (state == LOCKED);
  assign credit_cnt_o = credit_cnt;
  assign err_o        = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (found) begin
      if (tail_i[win]) begin
        state  <= IDLE;
        rr_ptr <= win_next;
      end else if (state == IDLE) begin
        state <= LOCKED;
        owner <= win;
      end
    end
  end

  // Simultaneous transfer and return cancel; a return into a full counter is a protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CW'(CREDITS);
      err        <= 1'b0;
    end else begin
      case ({found, credit_ret_i})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: begin
          if (credit_cnt == CW'(CREDITS))
            err <= 1'b1;
          else
            credit_cnt <= credit_cnt + 1'b1;
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_outport_alloc.sv
// Directed bench for noc_outport_alloc: reset, round-robin, wormhole lock, credit stall/return, overflow, mid-packet reset.
module tb_noc_outport_alloc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_i;
  logic [4:0] tail_i;
  logic       credit_ret_i;
  logic [4:0] grant_o;
  logic       xfer_o;
  logic [2:0] sel_o;
  logic       busy_o;
  logic [2:0] credit_cnt_o;
  logic       err_o;

  int n_cmp = 0;
  int n_err = 0;

  noc_outport_alloc #(.NPORT(5), .CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .tail_i       (tail_i),
    .credit_ret_i (credit_ret_i),
    .grant_o      (grant_o),
    .xfer_o       (xfer_o),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
    req_i        = r;
    tail_i       = t;
    credit_ret_i = c;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(5'b11111, 5'b11111, 1'b0);
    cyc();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_xfer", 32'(xfer_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_credit", 32'(credit_cnt_o), 32'd4);
    drive(5'b00000, 5'b00000, 1'b0);
    rst = 1'b0;
    cyc();
    chk("idle_credit", 32'(credit_cnt_o), 32'd4);
    chk("idle_grant", 32'(grant_o), 32'h0);
    chk("idle_busy", 32'(busy_o), 32'h0);
    chk("idle_err", 32'(err_o), 32'h0);

    // Single-flit packets from every port with a credit returned each cycle.
    drive(5'b11111, 5'b11111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(grant_o), 32'(5'b00001 << k));
      chk("rr_sel", 32'(sel_o), 32'(k));
      chk("rr_xfer", 32'(xfer_o), 32'h1);
      cyc();
      chk("rr_credit", 32'(credit_cnt_o), 32'd4);
    end

    // Port 1 single flit moves rr_ptr to 2, then port 2 sends a 3-flit packet against port 0.
    drive(5'b00010, 5'b00010, 1'b1);
    chk("pre_grant", 32'(grant_o), 32'h02);
    cyc();
    drive(5'b00101, 5'b00000, 1'b1);
    chk("wh_f1_grant", 32'(grant_o), 32'h04);
    chk("wh_f1_sel", 32'(sel_o), 32'd2);
    cyc();
    chk("wh_f1_busy", 32'(busy_o), 32'h1);
    chk("wh_f2_grant", 32'(grant_o), 32'h04);
    cyc();
    chk("wh_f2_busy", 32'(busy_o), 32'h1);
    drive(5'b00101, 5'b00100, 1'b1);
    chk("wh_f3_grant", 32'(grant_o), 32'h04);
    chk("wh_f3_busy", 32'(busy_o), 32'h1);
    cyc();
    chk("wh_end_busy", 32'(busy_o), 32'h0);
    drive(5'b00001, 5'b00001, 1'b1);
    chk("wh_p0_grant", 32'(grant_o), 32'h01);
    chk("wh_p0_sel", 32'(sel_o), 32'd0);
    cyc();
    chk("wh_credit", 32'(credit_cnt_o), 32'd4);

    // Port 1 streams with no credit returns: 4 flits, then stall.
    drive(5'b00010, 5'b00000, 1'b0);
    chk("cs_f1_grant", 32'(grant_o), 32'h02);
    cyc();
    cyc();
    cyc();
    chk("cs_f4_grant", 32'(grant_o), 32'h02);
    cyc();
    chk("cs_zero_credit", 32'(credit_cnt_o), 32'd0);
    chk("cs_zero_grant", 32'(grant_o), 32'h0);
    chk("cs_zero_xfer", 32'(xfer_o), 32'h0);
    chk("cs_zero_busy", 32'(busy_o), 32'h1);
    drive(5'b00010, 5'b00000, 1'b1);
    chk("cs_ret_grant", 32'(grant_o), 32'h0);
    cyc();
    drive(5'b00010, 5'b00000, 1'b0);
    chk("cs_ret_credit", 32'(credit_cnt_o), 32'd1);
    chk("cs_f5_grant", 32'(grant_o), 32'h02);
    cyc();
    chk("cs_f5_credit", 32'(credit_cnt_o), 32'd0);
    chk("cs_f5_after", 32'(grant_o), 32'h0);
    chk("cs_f5_busy", 32'(busy_o), 32'h1);

    // Owner bubble while credits return: lock held, no transfer.
    drive(5'b01000, 5'b01000, 1'b1);
    chk("bub_grant", 32'(grant_o), 32'h0);
    cyc();
    chk("bub_grant2", 32'(grant_o), 32'h0);
    cyc();
    chk("bub_busy", 32'(busy_o), 32'h1);
    chk("bub_credit", 32'(credit_cnt_o), 32'd2);

    // Transfer plus credit return at count 2 for three cycles.
    drive(5'b00010, 5'b00010, 1'b1);
    chk("sim_a_grant", 32'(grant_o), 32'h02);
    cyc();
    chk("sim_a_credit", 32'(credit_cnt_o), 32'd2);
    chk("sim_a_busy", 32'(busy_o), 32'h0);
    drive(5'b00100, 5'b00100, 1'b1);
    chk("sim_b_grant", 32'(grant_o), 32'h04);
    cyc();
    chk("sim_b_credit", 32'(credit_cnt_o), 32'd2);
    drive(5'b01000, 5'b01000, 1'b1);
    chk("sim_c_grant", 32'(grant_o), 32'h08);
    cyc();
    chk("sim_c_credit", 32'(credit_cnt_o), 32'd2);

    // Refill, then one extra return overflows.
    drive(5'b00000, 5'b00000, 1'b1);
    cyc();
    cyc();
    drive(5'b00000, 5'b00000, 1'b0);
    chk("fill_credit", 32'(credit_cnt_o), 32'd4);
    chk("fill_err", 32'(err_o), 32'h0);
    drive(5'b00000, 5'b00000, 1'b1);
    cyc();
    drive(5'b00000, 5'b00000, 1'b0);
    chk("ovf_credit", 32'(credit_cnt_o), 32'd4);
    chk("ovf_err", 32'(err_o), 32'h1);
    cyc();
    chk("ovf_err_sticky", 32'(err_o), 32'h1);

    // Port 4 (rr_ptr=4) starts a packet; reset mid-packet drops the lock and rr_ptr.
    drive(5'b10000, 5'b00000, 1'b0);
    chk("mr_grant", 32'(grant_o), 32'h10);
    cyc();
    chk("mr_busy", 32'(busy_o), 32'h1);
    chk("mr_credit", 32'(credit_cnt_o), 32'd3);
    rst = 1'b1;
    #1;
    chk("mr_rst_busy", 32'(busy_o), 32'h0);
    chk("mr_rst_credit", 32'(credit_cnt_o), 32'd4);
    chk("mr_rst_grant", 32'(grant_o), 32'h0);
    chk("mr_rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;
    drive(5'b10011, 5'b10011, 1'b0);
    chk("mr_rearb_grant", 32'(grant_o), 32'h01);
    cyc();
    chk("mr_rearb_credit", 32'(credit_cnt_o), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
